// File: rtl/pipe_stall_ctrl.sv
// ---------------------------------------------------------------------------
// PipeStallCtrl : hazard / stall controller for a classic 5-stage pipeline.
//
// Decides each cycle whether the front of the pipe advances, stalls, flushes
// or freezes. The decision depends on a load-use hazard, a taken branch and a
// data-memory handshake. A memory access that stays not-ready for TIMEOUT
// consecutive cycles parks the controller in a sticky error state. Only reset
// leaves that state.
//
// Parameters
//   TIMEOUT  consecutive memory not-ready cycles that trigger ERR (2..255)
//   CNT_W    width of the stall performance counter
//
// Ports
//   i_clk            clock, all state updates on the rising edge
//   i_rst            synchronous reset, active-high
//   i_lu_hazard      load-use hazard between IF/ID sources and ID/EX load
//   i_branch_taken   taken branch / jump resolved in EX this cycle
//   i_mem_req        instruction in MEM needs the data memory
//   i_mem_ready      data memory completes the MEM access this cycle
//   o_pc_write       PC update enable
//   o_if_id_write    IF/ID write enable
//   o_if_id_flush    clear IF/ID to a NOP
//   o_id_ex_bubble   zero control into ID/EX
//   o_ex_mem_write   ID/EX and EX/MEM write enable
//   o_mem_wb_bubble  write a bubble into MEM/WB
//   o_timeout_err    sticky memory-timeout flag
//   o_stall_cnt      cycles with o_pc_write=0 since reset (saturating)
// ---------------------------------------------------------------------------
module pipe_stall_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_lu_hazard,
    input  logic             i_branch_taken,
    input  logic             i_mem_req,
    input  logic             i_mem_ready,
    output logic             o_pc_write,
    output logic             o_if_id_write,
    output logic             o_if_id_flush,
    output logic             o_id_ex_bubble,
    output logic             o_ex_mem_write,
    output logic             o_mem_wb_bubble,
    output logic             o_timeout_err,
    output logic [CNT_W-1:0] o_stall_cnt
);

    // The wait counter only has to reach TIMEOUT-1. It is sized for TIMEOUT,
    // so it has headroom and can never wrap.
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [WAIT_W-1:0] r_waitCnt;
    logic [WAIT_W-1:0] w_nextWaitCnt;
    logic              r_timeoutErr;
    logic [CNT_W-1:0]  r_stallCnt;
    logic              w_memStall;

    // The memory holds the pipe whenever an access is pending and not yet done.
    assign w_memStall = i_mem_req && !i_mem_ready;

    // State register plus the other registered bookkeeping.
    // The timeout flag is set on the edge that enters ERR and is held there.
    // The stall counter counts each cycle the PC is held. Reset cycles are
    // not counted. The counter sticks at all-ones.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= RUN;
            r_waitCnt    <= '0;
            r_timeoutErr <= 1'b0;
            r_stallCnt   <= '0;
        end else begin
            r_state   <= w_nextState;
            r_waitCnt <= w_nextWaitCnt;
            if (w_nextState == ERR) begin
                r_timeoutErr <= 1'b1;
            end
            if (!o_pc_write && (r_stallCnt != {CNT_W{1'b1}})) begin
                r_stallCnt <= r_stallCnt + CNT_ONE;
            end
        end
    end

    // Next-state and wait-counter logic.
    // The wait counter counts freeze cycles that have already happened.
    // Entering MEM_WAIT loads 1, because the RUN cycle that entered it already
    // froze the pipe. When the counter reaches TIMEOUT-1 with memory still
    // not ready, that cycle is freeze number TIMEOUT, so the next state is ERR.
    always_comb begin
        w_nextState   = r_state;
        w_nextWaitCnt = r_waitCnt;
        case (r_state)
            RUN: begin
                if (w_memStall) begin
                    w_nextState   = MEM_WAIT;
                    w_nextWaitCnt = WAIT_ONE;
                end
            end
            MEM_WAIT: begin
                if (w_memStall) begin
                    if (r_waitCnt == WAIT_LAST) begin
                        w_nextState = ERR;
                    end else begin
                        w_nextWaitCnt = r_waitCnt + WAIT_ONE;
                    end
                end else begin
                    w_nextState   = RUN;
                    w_nextWaitCnt = '0;
                end
            end
            ERR: begin
                w_nextState = ERR;
            end
            default: begin
                w_nextState   = RUN;
                w_nextWaitCnt = '0;
            end
        endcase
    end

    // Output decode.
    // RUN and MEM_WAIT decode the same way. A pending memory access freezes
    // everything. Otherwise a taken branch flushes IF/ID and bubbles ID/EX;
    // it also wins over a load-use hazard, because the dependent instruction
    // is squashed anyway. Failing both, a load-use hazard holds PC and IF/ID
    // and bubbles ID/EX. The load-use stall has no state of its own and
    // follows i_lu_hazard directly. Reset forces a safe, fully flushed pattern.
    always_comb begin
        o_pc_write      = 1'b1;
        o_if_id_write   = 1'b1;
        o_if_id_flush   = 1'b0;
        o_id_ex_bubble  = 1'b0;
        o_ex_mem_write  = 1'b1;
        o_mem_wb_bubble = 1'b0;
        if (i_rst) begin
            o_pc_write      = 1'b0;
            o_if_id_write   = 1'b0;
            o_if_id_flush   = 1'b1;
            o_id_ex_bubble  = 1'b1;
            o_ex_mem_write  = 1'b0;
            o_mem_wb_bubble = 1'b1;
        end else begin
            case (r_state)
                RUN, MEM_WAIT: begin
                    if (w_memStall) begin
                        o_pc_write      = 1'b0;
                        o_if_id_write   = 1'b0;
                        o_ex_mem_write  = 1'b0;
                        o_mem_wb_bubble = 1'b1;
                    end else if (i_branch_taken) begin
                        o_if_id_flush  = 1'b1;
                        o_id_ex_bubble = 1'b1;
                    end else if (i_lu_hazard) begin
                        o_pc_write     = 1'b0;
                        o_if_id_write  = 1'b0;
                        o_id_ex_bubble = 1'b1;
                    end
                end
                default: begin
                    o_pc_write      = 1'b0;
                    o_if_id_write   = 1'b0;
                    o_ex_mem_write  = 1'b0;
                    o_mem_wb_bubble = 1'b1;
                end
            endcase
        end
    end

    assign o_timeout_err = r_timeoutErr;
    assign o_stall_cnt   = r_stallCnt;

endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16: consecutive memory not-ready cycles that trigger the error state (legal range 2..255).
REQ-002 The block SHALL have parameter CNT_W, default 16: width of the stall performance counter.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous reset, active-high.
REQ-006 lu_hazard  input  1  load-use hazard detected between IF/ID sources and an ID/EX load destination.
REQ-007 branch_taken  input  1  taken branch or jump resolved in EX this cycle.
REQ-008 mem_req  input  1  the instruction in MEM is a load or store needing the data memory.
REQ-009 mem_ready  input  1  data memory completes the MEM-stage access this cycle.
REQ-010 pc_write  output  1  PC update enable.
REQ-011 if_id_write  output  1  IF/ID register write enable.
REQ-012 if_id_flush  output  1  clear IF/ID to a NOP.
REQ-013 id_ex_bubble  output  1  select zero control into ID/EX (bubble).
REQ-014 ex_mem_write  output  1  ID/EX and EX/MEM register write enable.
REQ-015 mem_wb_bubble  output  1  write a bubble into MEM/WB.
REQ-016 timeout_err  output  1  sticky memory-timeout flag.
REQ-017 stall_cnt  output  CNT_W  count of cycles with pc_write=0 since reset.

Function
REQ-018 The FSM SHALL have three states: RUN, MEM_WAIT and ERR.
REQ-019 All control outputs SHALL be combinational from state and inputs; state, wait_cnt, timeout_err and stall_cnt SHALL be registered.
REQ-020 Normal mode SHALL drive pc_write=1, if_id_write=1, ex_mem_write=1 and all flush/bubble outputs 0.
REQ-021 Mem-freeze mode SHALL drive pc_write=0, if_id_write=0, ex_mem_write=0, if_id_flush=0, id_ex_bubble=0, mem_wb_bubble=1.
REQ-022 Priority in RUN SHALL be: mem freeze > branch flush > load-use stall > normal.
REQ-023 RUN with mem_req=1 and mem_ready=0 SHALL select mem-freeze mode, go to MEM_WAIT and load wait_cnt=1.
REQ-024 RUN with branch_taken=1 and no freeze SHALL drive normal mode plus if_id_flush=1 and id_ex_bubble=1; lu_hazard is ignored that cycle.
REQ-025 RUN with lu_hazard=1 and no freeze or branch SHALL drive pc_write=0, if_id_write=0 and id_ex_bubble=1, with the other outputs normal.
REQ-026 The load-use stall SHALL last exactly as long as lu_hazard is asserted, with no internal state.
REQ-027 MEM_WAIT with mem_req=1 and mem_ready=0 SHALL stay in mem-freeze mode; branch_taken and lu_hazard are ignored.
REQ-028 In that MEM_WAIT case, if wait_cnt==TIMEOUT-1 the next state SHALL be ERR; otherwise wait_cnt SHALL increment.
REQ-029 MEM_WAIT with mem_ready=1 or mem_req=0 SHALL evaluate outputs exactly as RUN with no freeze (branch > load-use > normal), go to RUN and clear wait_cnt.
REQ-030 ERR SHALL drive mem-freeze outputs and timeout_err=1, and SHALL leave ERR only on rst.
REQ-031 timeout_err SHALL assert on the edge entering ERR.
REQ-032 stall_cnt SHALL increment on each edge where pc_write=0 and rst=0, and SHALL saturate at all-ones.
REQ-033 ERR cycles SHALL count toward stall_cnt.
REQ-034 wait_cnt SHALL be ceil(log2(TIMEOUT+1)) bits wide and SHALL never wrap.

Reset
REQ-035 While rst=1, outputs SHALL be pc_write=0, if_id_write=0, ex_mem_write=0, if_id_flush=1, id_ex_bubble=1, mem_wb_bubble=1.
REQ-036 On a rst edge: state=RUN, wait_cnt=0, timeout_err=0, stall_cnt=0.
REQ-037 Reset asserted in MEM_WAIT or ERR SHALL abort the wait and the error with no residual state.
REQ-038 Reset cycles SHALL not increment stall_cnt.

Verification
REQ-039 Load-use: in RUN, lu_hazard=1 for 1 cycle -> pc_write=0, if_id_write=0, id_ex_bubble=1 for that cycle; then normal; stall_cnt=1.
REQ-040 Branch vs load-use: branch_taken=1 and lu_hazard=1 together -> pc_write=1, if_id_flush=1, id_ex_bubble=1; stall_cnt unchanged.
REQ-041 Mem wait: mem_req=1, mem_ready=0 for 3 cycles, then 1 -> 3 freeze cycles with mem_wb_bubble=1, then normal in the ready cycle, state RUN; stall_cnt=3.
REQ-042 Timeout: TIMEOUT=4, mem_req=1, mem_ready=0 held -> timeout_err=1 after the 4th freeze cycle; outputs stay frozen if mem_ready later asserts; rst clears everything.
REQ-043 Ready with branch: branch_taken=1 held during MEM_WAIT -> flush suppressed while waiting; flush asserted in the mem_ready cycle only.
REQ-044 Saturation: CNT_W=4, 20 lu_hazard cycles -> stall_cnt=15 and holds.
